mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequences one dot-product job through the MAC subsystem: accepts a job descriptor,
//  streams operand pairs into the multiply/align/accumulate pipe, drains it, then strobes
//  the normaliser/exponent-handling stage and holds the FP16 result for a consumer.
//  Sits between the operand buffer and the MAC datapath; the datapath itself is not included.
// PARAMETERS
//  LEN_W     8  width of job length (max 2^LEN_W-1 pairs)
//  PIPE_LAT  3  cycles from accepted mac_en beat to accumulator valid
//  NORM_LAT  1  cycles from norm_go to MAC_output valid at datapath
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  cfg_valid   in   1      job descriptor valid
//  cfg_ready   out  1      controller can accept a job (IDLE only)
//  cfg_len     in   LEN_W  number of operand pairs
//  cfg_q_frac  in   5      fractional shift forwarded to exponent stage
//  src_valid   in   1      operand pair available from buffer
//  src_ready   out  1      operand pair consumed this cycle
//  src_addr    out  LEN_W  index of pair being consumed
//  mac_clr     out  1      one-cycle accumulator clear
//  mac_en      out  1      accumulate current pair (= src_valid & src_ready)
//  norm_go     out  1      one-cycle strobe: latch normaliser inputs
//  q_frac      out  5      registered cfg_q_frac, stable for whole job
//  mac_in      in   16     MAC_output from exponent-handling stage
//  res_valid   out  1      result valid
//  res_ready   in   1      consumer accepts result
//  res_data    out  16     registered FP16 result
//  busy        out  1      high in any state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except cfg_ready=1; counters 0; res_data 0.
//  - FSM: IDLE -> CLR -> RUN -> DRAIN -> NORM -> OUT -> IDLE.
//  - IDLE: cfg_ready=1; on cfg_valid latch len, q_frac; go CLR. No cfg accepted elsewhere.
//  - CLR: mac_clr=1 one cycle; idx=0; if len==0 go DRAIN directly (skip RUN).
//  - RUN: src_ready=1, src_addr=idx; each beat with src_valid: mac_en=1, idx++.
//    src_valid low = bubble, no mac_en, idx held. Beat with idx==len-1 -> DRAIN.
//  - DRAIN: count PIPE_LAT cycles after last beat (counter loads PIPE_LAT-1, decrements);
//    at 0 -> NORM. len==0 also waits PIPE_LAT (clear must settle).
//  - NORM: norm_go=1 first cycle; wait NORM_LAT cycles; then capture mac_in into res_data -> OUT.
//  - OUT: res_valid=1, res_data stable until res_valid&res_ready, then IDLE.
//    res_ready high on entry -> exactly one res_valid cycle.
//  - Latency, no bubbles/stalls: cfg accept to res_valid = 1+len+PIPE_LAT+NORM_LAT+1 cycles.
//  - len==0 yields datapath zero path: res_data = {sign,15'd0} as provided by datapath.
//  - idx counter LEN_W bits, never wraps (terminates at len-1); len=2^LEN_W-1 legal.
//  - rst mid-job: immediate IDLE next edge; partial results discarded, no res_valid.
//  - src_valid ignored outside RUN; res_ready ignored outside OUT.
// CONFIGURATION
//  MAC_SEQ_STALL_CNT_EN defined: adds output stall_cnt[15:0]; counts RUN cycles with
//   src_valid=0 plus OUT cycles with res_ready=0; cleared on CLR entry; saturates at 16'hFFFF;
//   reset 0. Undefined: port and counter absent, no other change.
// STRUCTURE
//  Shared package mac_pkg: state encoding localparams (IDLE..OUT, 3 bits), FP16 width 16,
//  Q_FRAC_W=5. One sub-module natural: mac_seq_cnt (loadable down-counter, zero flag)
//  reused for DRAIN and NORM waits. FSM, idx counter and result register in top.
// TESTING
//  1 reset: rst=1 3 cycles -> cfg_ready=1, busy=0, res_valid=0, all strobes 0.
//  2 len=4, src_valid=1 always, res_ready=1 -> mac_en 4 consecutive, src_addr 0..3,
//    res_valid exactly 10 cycles after cfg accept (defaults), res_data == mac_in sampled.
//  3 len=4, src_valid 1,0,0,1,1,0,1 -> mac_en only on high beats, addr holds during gaps,
//    latency grows by 3; STALL_CNT_EN build stall_cnt=3.
//  4 len=0 -> mac_clr then no mac_en, norm_go after PIPE_LAT, res_valid with datapath zero.
//  5 res_ready low 5 cycles in OUT -> res_valid/res_data stable, cfg_ready=0 throughout,
//    new cfg_valid ignored; accepted 1 cycle after handshake.
//  6 rst pulse during RUN idx=2 -> IDLE next cycle, mac_en=0, no res_valid for that job.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing slice: controller state encoding and
// datapath field widths.
package mac_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam int unsigned Q_FRAC_W = 5;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StNorm  = 3'd4,
    StOut   = 3'd5
  } mac_state_e;

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with zero flag; times the pipe-drain and normaliser waits.
module mac_seq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: accept descriptor, clear accumulator, stream operand pairs,
// drain the MAC pipe, strobe the normaliser and hold the FP16 result for the consumer.
// Optional build macro MAC_SEQ_STALL_CNT_EN adds the stall_cnt output.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned NORM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [Q_FRAC_W-1:0] cfg_q_frac,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [LEN_W-1:0]    src_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                norm_go,
  output logic [Q_FRAC_W-1:0] q_frac,
  input  logic [FP16_W-1:0]   mac_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [FP16_W-1:0]   res_data,
  output logic                busy
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] NORM_LOAD  = CNT_W'(NORM_LAT - 1);

  mac_state_e          state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [Q_FRAC_W-1:0] q_frac_q;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [FP16_W-1:0]   res_q;
  logic                cfg_accept;
  logic                res_capture;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_dec;
  logic [CNT_W-1:0]    cnt_count;
  logic                cnt_zero;

  assign cfg_accept = (state_q == StIdle) && cfg_valid;
  assign cnt_dec    = (state_q == StDrain) || (state_q == StNorm);

  mac_seq_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // State, job descriptor, pair index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      q_frac_q <= '0;
      idx_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cfg_accept) begin
        len_q    <= cfg_len;
        q_frac_q <= cfg_q_frac;
      end
      if (res_capture) begin
        res_q <= mac_in;
      end
    end
  end

  // Next-state, index update and wait-counter loads.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_load    = 1'b0;
    cnt_val     = DRAIN_LOAD;
    res_capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) state_d = StClr;
      end
      StClr: begin
        idx_d = '0;
        if (len_q == '0) begin
          // Empty job still waits out the pipe so the clear settles.
          state_d  = StDrain;
          cnt_load = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (src_valid) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d  = StDrain;
            cnt_load = 1'b1;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      StDrain: begin
        if (cnt_zero) begin
          state_d  = StNorm;
          cnt_load = 1'b1;
          cnt_val  = NORM_LOAD;
        end
      end
      StNorm: begin
        if (cnt_zero) begin
          state_d     = StOut;
          res_capture = 1'b1;
        end
      end
      StOut: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from state; mac_en qualifies the handshake.
  always_comb begin
    cfg_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    mac_clr   = (state_q == StClr);
    src_ready = (state_q == StRun);
    mac_en    = src_valid && (state_q == StRun);
    // Counter still holds its load value only on the first NORM cycle.
    norm_go   = (state_q == StNorm) && (cnt_count == NORM_LOAD);
    res_valid = (state_q == StOut);
    src_addr  = idx_q;
    q_frac    = q_frac_q;
    res_data  = res_q;
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_evt;

  assign stall_evt = ((state_q == StRun) && !src_valid) || ((state_q == StOut) && !res_ready);

  // Saturating stall counter, restarted for each accepted job.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (cfg_accept) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: reset, streaming, bubbles, empty job, output
// back-pressure with a held descriptor, maximum length and mid-job reset.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_len;
  logic [4:0]  cfg_q_frac;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  src_addr;
  logic        mac_clr;
  logic        mac_en;
  logic        norm_go;
  logic [4:0]  q_frac;
  logic [15:0] mac_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_len    (cfg_len),
    .cfg_q_frac (cfg_q_frac),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .norm_go    (norm_go),
    .q_frac     (q_frac),
    .mac_in     (mac_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One job: accept in cycle 0, CLR in cycle 1, RUN from cycle 2. exp_run is the number
  // of RUN cycles, so norm_go lands at exp_run+5 and res_valid at exp_run+6.
  task automatic run_job(input logic [7:0] len, input logic [15:0] pat, input int ready_delay,
                         input logic [15:0] val, input logic [4:0] qf, input bit poke,
                         input int exp_run, input int exp_stall);
    int  beats      = 0;
    int  clr_cycle  = -1;
    int  norm_cycle = -1;
    int  norm_cnt   = 0;
    int  lat        = -1;
    int  out_cnt    = 0;
    bit  done       = 0;
    int  exp_norm   = exp_run + 5;
    int  exp_lat    = exp_run + 6;
    cfg_valid  = 1'b1;
    cfg_len    = len;
    cfg_q_frac = qf;
    mac_in     = 16'hdead;
    #1;
    check_val("cfg_ready_idle", cfg_ready, 1);
    next_cycle();
    cfg_valid  = 1'b0;
    cfg_len    = 8'h5a;
    cfg_q_frac = 5'h1f;
    for (int n = 1; n < 400 && !done; n++) begin
      src_valid = (n >= 2 && n - 2 < 16) ? pat[n-2] : 1'b1;
      mac_in    = (n >= exp_norm && n <= exp_lat) ? val : 16'hdead;
      res_ready = (out_cnt >= ready_delay);
      cfg_valid = poke && (n >= exp_lat);
      #1;
      if (mac_clr) clr_cycle = n;
      if (mac_en) begin
        check_val("src_addr", src_addr, beats);
        beats++;
      end else if (src_ready) begin
        check_val("addr_hold", src_addr, beats);
      end
      if (norm_go) begin
        norm_cnt++;
        norm_cycle = n;
      end
      if (res_valid) begin
        if (out_cnt == 0) lat = n;
        check_val(out_cnt == 0 ? "res_data" : "res_hold", res_data, val);
        check_val("cfg_ready_out", cfg_ready, 0);
        out_cnt++;
        if (res_ready) done = 1;
      end
      if (!done) next_cycle();
    end
    if (!done) check_val("timeout", 0, 1);
    check_val("clr_cycle", clr_cycle, 1);
    check_val("beats", beats, len);
    check_val("norm_cnt", norm_cnt, 1);
    check_val("norm_cycle", norm_cycle, exp_norm);
    check_val("latency", lat, exp_lat);
    check_val("out_cycles", out_cnt, ready_delay + 1);
    check_val("q_frac", q_frac, qf);
    next_cycle();
    check_val("idle_after", busy, 0);
    check_val("res_valid_after", res_valid, 0);
`ifdef MAC_SEQ_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, exp_stall);
`else
    if (exp_stall < 0) check_val("stall_arg", exp_stall, 0);
`endif
  endtask

  initial begin
    int rv_cnt;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_len    = 8'd0;
    cfg_q_frac = 5'd0;
    src_valid  = 1'b1;
    res_ready  = 1'b1;
    mac_in     = 16'h1234;
    repeat (3) next_cycle();
    check_val("rst_cfg_ready", cfg_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_mac_clr", mac_clr, 0);
    check_val("rst_mac_en", mac_en, 0);
    check_val("rst_norm_go", norm_go, 0);
    check_val("rst_src_ready", src_ready, 0);
    check_val("rst_res_data", res_data, 0);
    check_val("rst_q_frac", q_frac, 0);
    check_val("rst_src_addr", src_addr, 0);
    rst = 1'b0;
    next_cycle();

    // Streaming job, no bubbles.
    run_job(8'd4, 16'hffff, 0, 16'h3c00, 5'd7, 1'b0, 4, 0);
    // Bubbles 1,0,0,1,1,0,1 on src_valid.
    run_job(8'd4, 16'hff59, 0, 16'h4248, 5'd3, 1'b0, 7, 3);
    // Empty job: datapath zero path.
    run_job(8'd0, 16'hffff, 0, 16'h8000, 5'd0, 1'b0, 0, 0);
    // Back-pressure in OUT with a new descriptor held throughout.
    run_job(8'd2, 16'hffff, 5, 16'hc500, 5'd12, 1'b1, 2, 5);
    // Held descriptor is taken right after the handshake.
    run_job(8'd1, 16'hffff, 0, 16'h0001, 5'd31, 1'b0, 1, 0);
    // Maximum length.
    run_job(8'd255, 16'hffff, 0, 16'h7bff, 5'd9, 1'b0, 255, 0);

    // Reset while streaming at idx 2.
    cfg_valid = 1'b1;
    cfg_len   = 8'd4;
    src_valid = 1'b1;
    res_ready = 1'b1;
    next_cycle();
    cfg_valid = 1'b0;
    repeat (3) next_cycle();
    check_val("mid_addr", src_addr, 2);
    check_val("mid_mac_en", mac_en, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_val("mid_busy", busy, 0);
    check_val("mid_mac_en_off", mac_en, 0);
    check_val("mid_cfg_ready", cfg_ready, 1);
    check_val("mid_res_data", res_data, 0);
    rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) rv_cnt++;
      next_cycle();
    end
    check_val("mid_no_result", rv_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
